// File: rtl/upp_frame_scheduler_if.sv
// uPP bus between the frame scheduler (master) and the DSP (slave).
interface upp_frame_scheduler_if;
  logic [15:0] oUPP_DATA;
  logic        oUPP_START;
  logic        oUPP_ENABLE;
  logic        iUPP_WAIT;

  modport master (output oUPP_DATA, output oUPP_START, output oUPP_ENABLE, input iUPP_WAIT);
  modport slave  (input oUPP_DATA, input oUPP_START, input oUPP_ENABLE, output iUPP_WAIT);
endinterface

// File: rtl/upp_frame_scheduler.sv
// Drains finished BLVDS frames from two ping-pong FIFOs onto the uPP bus, oldest bank first.
// Optional frame trailer word is enabled by defining UPP_TRAILER_EN.
module upp_frame_scheduler #(
  parameter logic [15:0] MAX_WORDS    = 16'd4200,
  parameter logic [15:0] WAIT_TIMEOUT = 16'd1000,
  parameter logic [3:0]  CLR_CYCLES   = 4'd3
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iSEND_OK,
  input  logic                  iWR_SEL,
  input  logic                  iRX_ERROR,
  input  logic [1:0]            iRDEMPTY,
  input  logic [15:0]           iQ0,
  input  logic [15:0]           iQ1,
  output logic [1:0]            oRDREQ,
  output logic [1:0]            oACLR,
  upp_frame_scheduler_if.master upp,
  output logic                  oBUSY,
  output logic                  oOVERRUN,
  output logic                  oABORT,
  output logic [7:0]            oFRAME_CNT
);

`ifdef UPP_TRAILER_EN
  typedef enum logic [2:0] {ST_IDLE, ST_PREP, ST_XFER, ST_TRAIL, ST_CLEAR} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_PREP, ST_XFER, ST_CLEAR} state_t;
`endif

  state_t          state_q, state_d;
  logic            bank_q, bank_d, age_q, age_d;
  logic [1:0]      pend_q, pend_d;
  logic            ok_q, ev_q, ev_d, ev_bank_q, ev_err_q;
  logic [1:0][3:0] ecnt_q, ecnt_d;
  logic            ovr_q, ovr_d, abort_q, abort_d;
  logic [15:0]     hold_q, hold_d;
  logic            hold_v_q, hold_v_d, infl_q, infl_d, first_q, first_d;
  logic [15:0]     wcnt_q, wcnt_d, wait_cnt_q, wait_cnt_d;
  logic [3:0]      clr_cnt_q, clr_cnt_d;
  logic            aborted_q, aborted_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;

  logic [1:0]  rdreq, aclr, pend_clr, pend_set;
  logic        enable, consume, load, timeout, sel;
  logic [15:0] q_sel;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= ST_IDLE;
      bank_q      <= 1'b0;
      age_q       <= 1'b0;
      pend_q      <= '0;
      ok_q        <= 1'b0;
      ev_q        <= 1'b0;
      ev_bank_q   <= 1'b0;
      ev_err_q    <= 1'b0;
      ecnt_q      <= '0;
      ovr_q       <= 1'b0;
      abort_q     <= 1'b0;
      hold_q      <= '0;
      hold_v_q    <= 1'b0;
      infl_q      <= 1'b0;
      first_q     <= 1'b0;
      wcnt_q      <= '0;
      wait_cnt_q  <= '0;
      clr_cnt_q   <= '0;
      aborted_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      age_q       <= age_d;
      pend_q      <= pend_d;
      ok_q        <= iSEND_OK;
      ev_q        <= ev_d;
      ev_bank_q   <= iWR_SEL;
      ev_err_q    <= iRX_ERROR;
      ecnt_q      <= ecnt_d;
      ovr_q       <= ovr_d;
      abort_q     <= abort_d;
      hold_q      <= hold_d;
      hold_v_q    <= hold_v_d;
      infl_q      <= infl_d;
      first_q     <= first_d;
      wcnt_q      <= wcnt_d;
      wait_cnt_q  <= wait_cnt_d;
      clr_cnt_q   <= clr_cnt_d;
      aborted_q   <= aborted_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    age_d       = age_q;
    ev_d        = iSEND_OK & ~ok_q;
    ovr_d       = 1'b0;
    abort_d     = 1'b0;
    hold_d      = hold_q;
    hold_v_d    = hold_v_q;
    infl_d      = infl_q;
    first_d     = first_q;
    wcnt_d      = wcnt_q;
    wait_cnt_d  = '0;
    clr_cnt_d   = clr_cnt_q;
    aborted_d   = aborted_q;
    frame_cnt_d = frame_cnt_q;
    rdreq       = '0;
    aclr        = '0;
    enable      = 1'b0;
    pend_clr    = '0;
    pend_set    = '0;
    sel         = (&pend_q) ? ~age_q : pend_q[1];
    q_sel       = bank_q ? iQ1 : iQ0;
    consume     = hold_v_q & ~upp.iUPP_WAIT;
    load        = ~hold_v_q | consume;
    timeout     = upp.iUPP_WAIT && (wait_cnt_q >= WAIT_TIMEOUT - 16'd1);
    for (int unsigned b = 0; b < 2; b++)
      ecnt_d[b] = (ecnt_q[b] != 4'd0) ? ecnt_q[b] - 4'd1 : 4'd0;

    case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          bank_d    = sel;
          pend_clr  = sel ? 2'b10 : 2'b01;
          wcnt_d    = '0;
          first_d   = 1'b1;
          hold_v_d  = 1'b0;
          infl_d    = 1'b0;
          aborted_d = 1'b0;
          clr_cnt_d = '0;
          state_d   = ST_PREP;
        end
      end
      ST_PREP: begin
        if (iRDEMPTY[bank_q]) begin
          state_d = ST_CLEAR;
        end else begin
          rdreq[bank_q] = 1'b1;
          infl_d        = 1'b1;
          wcnt_d        = 16'd1;
          state_d       = ST_XFER;
        end
      end
      ST_XFER: begin
        enable     = hold_v_q;
        wait_cnt_d = upp.iUPP_WAIT ? wait_cnt_q + 16'd1 : 16'd0;
        if (consume) begin
          hold_v_d = 1'b0;
          first_d  = 1'b0;
        end
        if (infl_q && load) begin
          hold_d   = q_sel;
          hold_v_d = 1'b1;
          infl_d   = 1'b0;
        end
        // A read is only issued when the word now on the FIFO output moves into the holding register this edge.
        if (!upp.iUPP_WAIT && !iRDEMPTY[bank_q] && (wcnt_q != MAX_WORDS) && (!infl_q || load)) begin
          rdreq[bank_q] = 1'b1;
          infl_d        = 1'b1;
          wcnt_d        = wcnt_q + 16'd1;
        end
        if (timeout) begin
          abort_d   = 1'b1;
          aborted_d = 1'b1;
          state_d   = ST_CLEAR;
        end else if (!hold_v_q && !infl_q) begin
          if (iRDEMPTY[bank_q]) begin
`ifdef UPP_TRAILER_EN
            hold_d   = {4'hA, 3'b000, bank_q, frame_cnt_q + 8'd1};
            hold_v_d = 1'b1;
            state_d  = ST_TRAIL;
`else
            state_d  = ST_CLEAR;
`endif
          end else if (wcnt_q == MAX_WORDS) begin
            abort_d   = 1'b1;
            aborted_d = 1'b1;
            state_d   = ST_CLEAR;
          end
        end
      end
`ifdef UPP_TRAILER_EN
      ST_TRAIL: begin
        enable     = hold_v_q;
        wait_cnt_d = upp.iUPP_WAIT ? wait_cnt_q + 16'd1 : 16'd0;
        if (timeout) begin
          abort_d   = 1'b1;
          aborted_d = 1'b1;
          state_d   = ST_CLEAR;
        end else if (consume) begin
          hold_v_d = 1'b0;
          first_d  = 1'b0;
          state_d  = ST_CLEAR;
        end
      end
`endif
      ST_CLEAR: begin
        aclr[bank_q] = 1'b1;
        clr_cnt_d    = clr_cnt_q + 4'd1;
        if (clr_cnt_q == CLR_CYCLES - 4'd1) begin
          age_d   = bank_q;
          state_d = ST_IDLE;
          if (!aborted_q) frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Error clears on the bank being drained are covered by its own CLEAR.
    if (ev_q) begin
      if (ev_err_q) begin
        if (state_q == ST_IDLE || bank_q != ev_bank_q) ecnt_d[ev_bank_q] = CLR_CYCLES;
      end else begin
        pend_set[ev_bank_q] = 1'b1;
        if (pend_q[ev_bank_q] && !pend_clr[ev_bank_q]) ovr_d = 1'b1;
      end
    end
    pend_d = (pend_q & ~pend_clr) | pend_set;
  end

  assign oRDREQ          = rdreq;
  assign oACLR           = aclr | {ecnt_q[1] != 4'd0, ecnt_q[0] != 4'd0};
  assign upp.oUPP_DATA   = hold_q;
  assign upp.oUPP_ENABLE = enable;
  assign upp.oUPP_START  = enable & first_q;
  assign oBUSY           = (state_q != ST_IDLE);
  assign oOVERRUN        = ovr_q;
  assign oABORT          = abort_q;
  assign oFRAME_CNT      = frame_cnt_q;

endmodule

// File: tb/tb_upp_frame_scheduler.sv
// Directed bench for upp_frame_scheduler (default build, no trailer word) with two behavioural FIFOs.
module tb_upp_frame_scheduler;
  localparam int DEPTH = 16384;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iSEND_OK = 1'b0;
  logic        iWR_SEL = 1'b0;
  logic        iRX_ERROR = 1'b0;
  logic [1:0]  iRDEMPTY;
  logic [15:0] iQ0 = '0;
  logic [15:0] iQ1 = '0;
  logic [1:0]  oRDREQ, oACLR;
  logic        oBUSY, oOVERRUN, oABORT;
  logic [7:0]  oFRAME_CNT;

  upp_frame_scheduler_if upp_if();

  upp_frame_scheduler dut (
    .iCLK(iCLK), .iRST(iRST), .iSEND_OK(iSEND_OK), .iWR_SEL(iWR_SEL), .iRX_ERROR(iRX_ERROR),
    .iRDEMPTY(iRDEMPTY), .iQ0(iQ0), .iQ1(iQ1), .oRDREQ(oRDREQ), .oACLR(oACLR),
    .upp(upp_if.master), .oBUSY(oBUSY), .oOVERRUN(oOVERRUN), .oABORT(oABORT),
    .oFRAME_CNT(oFRAME_CNT)
  );

  always #5 iCLK = ~iCLK;

  // Behavioural FIFOs: 1-cycle read latency, q holds until the next read.
  logic [15:0] mem0 [DEPTH];
  logic [15:0] mem1 [DEPTH];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  assign iRDEMPTY = {rd1 == wr1, rd0 == wr0};

  always @(posedge iCLK) begin
    if (oACLR[0]) rd0 <= wr0;
    else if (oRDREQ[0] && rd0 != wr0) begin
      iQ0 <= mem0[rd0 % DEPTH];
      rd0 <= rd0 + 1;
    end
    if (oACLR[1]) rd1 <= wr1;
    else if (oRDREQ[1] && rd1 != wr1) begin
      iQ1 <= mem1[rd1 % DEPTH];
      rd1 <= rd1 + 1;
    end
  end

  // Bus monitor
  logic [15:0] rx[$];
  int en_cyc[$];
  int cyc = 0, n_start = 0, n_aclr0 = 0, n_aclr1 = 0, n_abort = 0, n_ovr = 0;
  int n_busy = 0, n_rdreq_wait = 0, n_hold_viol = 0;
  logic [15:0] start_word = '0;
  logic [15:0] prev_data = '0;
  logic prev_en_wait = 1'b0;

  always @(negedge iCLK) begin
    cyc <= cyc + 1;
    if (!iRST) begin
      if (upp_if.oUPP_ENABLE && !upp_if.iUPP_WAIT) begin
        rx.push_back(upp_if.oUPP_DATA);
        en_cyc.push_back(cyc);
        if (upp_if.oUPP_START) begin
          n_start <= n_start + 1;
          start_word <= upp_if.oUPP_DATA;
        end
      end
      if (oACLR[0]) n_aclr0 <= n_aclr0 + 1;
      if (oACLR[1]) n_aclr1 <= n_aclr1 + 1;
      if (oABORT) n_abort <= n_abort + 1;
      if (oOVERRUN) n_ovr <= n_ovr + 1;
      if (oBUSY) n_busy <= n_busy + 1;
      if (upp_if.iUPP_WAIT && (oRDREQ != 2'b00)) n_rdreq_wait <= n_rdreq_wait + 1;
      if (prev_en_wait && ((upp_if.oUPP_ENABLE && upp_if.oUPP_DATA != prev_data) ||
                           (!upp_if.oUPP_ENABLE && !oABORT)))
        n_hold_viol <= n_hold_viol + 1;
      prev_en_wait <= upp_if.oUPP_ENABLE && upp_if.iUPP_WAIT;
      prev_data <= upp_if.oUPP_DATA;
    end else begin
      prev_en_wait <= 1'b0;
    end
  end

  int n_cmp = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic fill(input logic bank, input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      if (bank) begin mem1[wr1 % DEPTH] = first + 16'(i); wr1++; end
      else      begin mem0[wr0 % DEPTH] = first + 16'(i); wr0++; end
    end
  endtask

  task automatic evt(input logic bank, input logic err);
    iWR_SEL = bank;
    iRX_ERROR = err;
    iSEND_OK = 1'b1;
    step();
    step();
    iSEND_OK = 1'b0;
    iRX_ERROR = 1'b0;
    step();
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int t = 0;
    while (rx.size() < n && t < budget) begin step(); t++; end
    check_eq(tag, rx.size() >= n, 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int t = 0, quiet = 0;
    while (quiet < 6 && t < budget) begin
      step();
      t++;
      quiet = oBUSY ? 0 : quiet + 1;
    end
    check_eq(tag, quiet >= 6, 1);
  endtask

  initial begin
    int b, s0, a0, a1, ab, ov, bz, rw, hv, t;
    upp_if.iUPP_WAIT = 1'b0;
    repeat (3) step();
    check_eq("rst_rdreq_aclr", {oRDREQ, oACLR}, 4'h0);
    check_eq("rst_bus", {upp_if.oUPP_ENABLE, upp_if.oUPP_START, upp_if.oUPP_DATA}, 18'h0);
    check_eq("rst_flags", {oBUSY, oOVERRUN, oABORT}, 3'b000);
    check_eq("rst_fcnt", oFRAME_CNT, 8'd0);
    iRST = 1'b0;
    step();

    // Single 8-word frame from bank 0
    b = rx.size(); s0 = n_start; a0 = n_aclr0;
    fill(1'b0, 16'h0001, 8);
    evt(1'b0, 1'b0);
    wait_idle(200, "f1_idle");
    check_eq("f1_count", rx.size() - b, 8);
    for (int i = 0; i < 8; i++) check_eq("f1_data", rx[b + i], 32'(i + 1));
    check_eq("f1_start_cnt", n_start - s0, 1);
    check_eq("f1_start_word", start_word, 16'h0001);
    check_eq("f1_span", en_cyc[b + 7] - en_cyc[b], 7);
    check_eq("f1_aclr0", n_aclr0 - a0, 3);
    check_eq("f1_fcnt", oFRAME_CNT, 8'd1);

    // Five WAIT cycles mid-frame
    b = rx.size(); rw = n_rdreq_wait; hv = n_hold_viol;
    fill(1'b0, 16'h0101, 16);
    evt(1'b0, 1'b0);
    wait_rx(b + 4, 100, "bp_start");
    upp_if.iUPP_WAIT = 1'b1;
    repeat (5) step();
    upp_if.iUPP_WAIT = 1'b0;
    wait_idle(200, "bp_idle");
    check_eq("bp_count", rx.size() - b, 16);
    for (int i = 0; i < 16; i++) check_eq("bp_data", rx[b + i], 32'h0101 + 32'(i));
    check_eq("bp_rdreq_in_wait", n_rdreq_wait - rw, 0);
    check_eq("bp_hold_stable", n_hold_viol - hv, 0);
    check_eq("bp_fcnt", oFRAME_CNT, 8'd2);

    // WAIT held until timeout
    b = rx.size(); ab = n_abort; a0 = n_aclr0;
    fill(1'b0, 16'h0201, 10);
    evt(1'b0, 1'b0);
    wait_rx(b + 3, 100, "to_start");
    upp_if.iUPP_WAIT = 1'b1;
    t = 0;
    while (!oABORT && t < 1100) begin step(); t++; end
    check_eq("to_wait_cycles", t, 1000);
    check_eq("to_enable_dropped", upp_if.oUPP_ENABLE, 1'b0);
    upp_if.iUPP_WAIT = 1'b0;
    wait_idle(200, "to_idle");
    check_eq("to_abort_pulses", n_abort - ab, 1);
    check_eq("to_aclr0", n_aclr0 - a0, 3);
    check_eq("to_fcnt", oFRAME_CNT, 8'd2);

    // Error frame on bank 1
    b = rx.size(); a1 = n_aclr1; bz = n_busy;
    fill(1'b1, 16'hEE00, 4);
    evt(1'b1, 1'b1);
    wait_idle(200, "err_idle");
    repeat (10) step();
    check_eq("err_no_traffic", rx.size() - b, 0);
    check_eq("err_never_busy", n_busy - bz, 0);
    check_eq("err_aclr1", n_aclr1 - a1, 3);
    check_eq("err_fifo1_cleared", iRDEMPTY[1], 1'b1);
    check_eq("err_fcnt", oFRAME_CNT, 8'd2);

    // Ping-pong: bank 1 event while bank 0 drains
    b = rx.size();
    fill(1'b0, 16'h0301, 6);
    fill(1'b1, 16'h0401, 5);
    evt(1'b0, 1'b0);
    wait_rx(b + 2, 100, "pp_start");
    evt(1'b1, 1'b0);
    wait_idle(300, "pp_idle");
    check_eq("pp_count", rx.size() - b, 11);
    for (int i = 0; i < 6; i++) check_eq("pp_b0_data", rx[b + i], 32'h0301 + 32'(i));
    for (int i = 0; i < 5; i++) check_eq("pp_b1_data", rx[b + 6 + i], 32'h0401 + 32'(i));
    check_eq("pp_gap", en_cyc[b + 6] - en_cyc[b + 5], 8);
    check_eq("pp_fcnt", oFRAME_CNT, 8'd4);

    // Overrun: two bank 0 events while bank 1 drains
    b = rx.size(); ov = n_ovr;
    fill(1'b1, 16'h0701, 16);
    fill(1'b0, 16'h0801, 4);
    evt(1'b1, 1'b0);
    wait_rx(b + 2, 100, "ov_start");
    evt(1'b0, 1'b0);
    evt(1'b0, 1'b0);
    wait_idle(300, "ov_idle");
    check_eq("ov_pulses", n_ovr - ov, 1);
    check_eq("ov_count", rx.size() - b, 20);
    check_eq("ov_b0_first", rx[b + 16], 16'h0801);
    check_eq("ov_b0_last", rx[b + 19], 16'h0804);
    check_eq("ov_fcnt", oFRAME_CNT, 8'd6);

    // Both pending after bank 0 served: bank 1 must go first
    b = rx.size(); ov = n_ovr;
    fill(1'b0, 16'h0901, 20);
    evt(1'b0, 1'b0);
    wait_rx(b + 2, 100, "arb_start");
    fill(1'b1, 16'h0A01, 3);
    evt(1'b1, 1'b0);
    evt(1'b0, 1'b0);
    wait_idle(300, "arb_idle");
    check_eq("arb_count", rx.size() - b, 23);
    check_eq("arb_b1_first", rx[b + 20], 16'h0A01);
    check_eq("arb_gap", en_cyc[b + 20] - en_cyc[b + 19], 8);
    check_eq("arb_no_overrun", n_ovr - ov, 0);
    check_eq("arb_fcnt", oFRAME_CNT, 8'd9);

    // Overlong frame
    b = rx.size(); ab = n_abort; a0 = n_aclr0;
    fill(1'b0, 16'h0001, 4300);
    evt(1'b0, 1'b0);
    wait_idle(6000, "ol_idle");
    check_eq("ol_count", rx.size() - b, 4200);
    check_eq("ol_last_word", rx[b + 4199], 16'd4200);
    check_eq("ol_abort_pulses", n_abort - ab, 1);
    check_eq("ol_aclr0", n_aclr0 - a0, 3);
    check_eq("ol_fcnt", oFRAME_CNT, 8'd9);

    // Reset in the middle of a transfer
    b = rx.size();
    fill(1'b0, 16'h0B00, 50);
    evt(1'b0, 1'b0);
    wait_rx(b + 5, 100, "mr_start");
    iRST = 1'b1;
    #1;
    check_eq("mr_bus", {upp_if.oUPP_ENABLE, upp_if.oUPP_START, upp_if.oUPP_DATA}, 18'h0);
    check_eq("mr_rdreq_aclr", {oRDREQ, oACLR}, 4'h0);
    check_eq("mr_flags", {oBUSY, oOVERRUN, oABORT}, 3'b000);
    check_eq("mr_fcnt", oFRAME_CNT, 8'd0);
    repeat (3) step();
    iRST = 1'b0;
    bz = n_busy;
    repeat (10) step();
    check_eq("mr_stays_idle", n_busy - bz, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/upp_frame_scheduler.md
Name: upp_frame_scheduler

Overview:
- Drains complete BLVDS frames from two ping-pong receive FIFOs (bank 0/1) onto the 16-bit uPP bus towards the DSP.
- Takes frame-complete and error status from the BLVDS receiver, queues banks holding a finished frame, and arbitrates between them (oldest first).
- Streams each frame with uPP START/ENABLE/WAIT handshaking, then clears the drained FIFO.

Parameters:
- MAX_WORDS, 16'd4200, maximum words read per frame; reaching it aborts the transfer as overlong.
- WAIT_TIMEOUT, 16'd1000, maximum consecutive cycles iUPP_WAIT may stay high before the transfer is aborted.
- CLR_CYCLES, 4'd3, number of cycles oACLR is held high for a bank.

Ports:
- iCLK  in  1  system clock
- iRST  in  1  reset, asynchronous, active-high
- iSEND_OK  in  1  receiver frame-done level; its rising edge marks one frame event
- iWR_SEL  in  1  bank the receiver was writing when iSEND_OK rose
- iRX_ERROR  in  1  OR of receiver head/epilog errors, sampled on the iSEND_OK rising edge
- iRDEMPTY  in  2  per-bank FIFO empty
- iQ0  in  16  bank 0 FIFO data, 1-cycle read latency
- iQ1  in  16  bank 1 FIFO data, 1-cycle read latency
- oRDREQ  out  2  per-bank read request
- oACLR  out  2  per-bank asynchronous clear request
- oUPP_DATA  out  16  uPP data
- oUPP_START  out  1  high with the first word of a frame
- oUPP_ENABLE  out  1  oUPP_DATA valid
- iUPP_WAIT  in  1  DSP back-pressure
- oBUSY  out  1  high in any state except IDLE
- oOVERRUN  out  1  1-cycle pulse when a frame event hits a bank that is already pending
- oABORT  out  1  1-cycle pulse on timeout or overlong frame
- oFRAME_CNT  out  8  frames fully sent, wraps 255 -> 0

Behaviour:
- Reset: all outputs 0, pending[1:0]=0, age pointer=0, state IDLE.
- iSEND_OK is registered and edge-detected; the event is acted on 1 cycle after the rising edge. A level held high produces no further events.
- Event with iRX_ERROR=1: no pending bit is set; oACLR[iWR_SEL] is pulsed for CLR_CYCLES, except when that bank is currently being drained, in which case the clear is deferred until CLEAR.
- Event with iRX_ERROR=0: pending[iWR_SEL] is set; if it was already set, oOVERRUN pulses and the single frame is kept.
- An event that arrives in the same cycle as a pending bit is cleared is registered, not lost.
- Arbitration in IDLE:
  - one pending bank -> that bank;
  - both pending -> the bank != last served (the age pointer).
  - The selected bank's pending bit clears on entry to PREP.
- States:
  - IDLE -> PREP when any bank is pending.
  - PREP: issue oRDREQ for the selected bank if !iRDEMPTY; if the bank is empty -> CLEAR with no uPP traffic.
  - XFER:
    - A 1-entry holding register captures the read data.
    - The held word is presented with oUPP_ENABLE=1; oUPP_START=1 only on the first word.
    - While iUPP_WAIT=1, data/enable/start are held and oRDREQ=0.
    - The next oRDREQ is issued only when the holding register is consumed or empty and !iRDEMPTY.
    - Throughput is 1 word/cycle with WAIT low.
    - Exits to TRAIL (or CLEAR) when the FIFO is empty and the holding register is drained.
  - TRAIL: see Optional Feature.
  - CLEAR: oACLR[bank]=1 for CLR_CYCLES, oUPP_ENABLE=0; then age pointer <= bank, oFRAME_CNT++ (not on abort) -> IDLE.
- Abort:
  - The word counter reaching MAX_WORDS, or the WAIT counter reaching WAIT_TIMEOUT, causes oABORT to pulse, drops oUPP_ENABLE the next cycle, and moves to CLEAR.
  - The WAIT counter resets whenever iUPP_WAIT=0.
- iRST mid-transfer: outputs return to 0 immediately, no partial clear is issued, and pending flags are lost.

Optional Feature:
- UPP_TRAILER_EN
  - Defined: after the last data word the TRAIL state sends one extra word {4'hA, 3'b0, bank, oFRAME_CNT+1}, obeying WAIT and the timeout exactly like data words.
  - Undefined: XFER goes directly to CLEAR and the TRAIL state is absent.

Test Plan:
- Single frame: bank0 holds 8 words 0x0001..0x0008, iSEND_OK rises with iWR_SEL=0, WAIT=0 -> oUPP_START with 0x0001, 8 consecutive ENABLE cycles, oACLR[0] high 3 cycles, oFRAME_CNT=1.
- Back-pressure: iUPP_WAIT high for 5 cycles mid-frame -> data held stable, no oRDREQ during WAIT, no word lost or duplicated; with WAIT held 1000 cycles -> oABORT, oACLR[0], oFRAME_CNT unchanged.
- Ping-pong: bank0 event, then a bank1 event during the bank0 transfer -> bank1 sent immediately after CLEAR of bank0; both pending with last served=0 -> bank1 first.
- Error frame: iSEND_OK rise with iRX_ERROR=1, iWR_SEL=1 -> no uPP traffic, oACLR[1] 3 cycles, pending=0.
- Overrun: two bank0 events while bank1 is transferring -> oOVERRUN one pulse, bank0 sent exactly once.
- Overlong: bank0 supplies more than MAX_WORDS words -> oABORT after word 4200, clear bank0, return to IDLE; reset asserted mid-XFER -> all outputs 0 in the same cycle.
